// File: rtl/spec_free_list_pkg.sv
// Shared sizing constants and tag/pointer types for the speculative free list.
package spec_free_list_pkg;
  localparam int PHYS_REGS = 96;
  localparam int LOG_REGS  = 32;
  localparam int PHYS_LOG  = 7;
  localparam int DEPTH     = PHYS_REGS - LOG_REGS;
  localparam int DEPTH_LOG = 6;
  localparam int SLOTS     = 4;

  typedef logic [PHYS_LOG-1:0]  phys_tag_t;
  typedef logic [DEPTH_LOG-1:0] fl_ptr_t;
  typedef logic [DEPTH_LOG:0]   fl_cnt_t;
endpackage

// File: rtl/spec_free_list_if.sv
// Release/rename-side bundle of the free list; the free list is the slave side.
interface spec_free_list_if;
  import spec_free_list_pkg::*;

  logic      releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i;
  phys_tag_t releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i;
  logic      reqFree_i;
  logic      recoverFlag_i;
  phys_tag_t freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o;
  logic      freeValid_o;
  fl_cnt_t   freeCount_o;
  logic      error_o;

  modport master (
    output releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
    output releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
    output reqFree_i, recoverFlag_i,
    input  freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
    input  freeValid_o, freeCount_o, error_o
  );

  modport slave (
    input  releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
    input  releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
    input  reqFree_i, recoverFlag_i,
    output freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
    output freeValid_o, freeCount_o, error_o
  );
endinterface

// File: rtl/spec_free_list_compact.sv
// Packs valid release slots into consecutive positions, preserving slot order.
module free_list_compact
  import spec_free_list_pkg::*;
(
  input  logic [3:0] valid_i,
  input  phys_tag_t  tag_i    [4],
  output phys_tag_t  tag_o    [4],
  output logic [2:0] npush_o,
  output logic [1:0] offset_o [4]
);

  logic [2:0] run;

  // offset_o[k] is the number of valid slots below k (exclusive prefix sum)
  always_comb begin
    run = '0;
    for (int k = 0; k < 4; k++) begin
      tag_o[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      offset_o[k] = run[1:0];
      if (valid_i[k]) begin
        tag_o[run[1:0]] = tag_i[k];
        run = run + 3'd1;
      end
    end
    npush_o = run;
  end

endmodule

// File: rtl/spec_free_list.sv
// Speculative physical-register free list (circular buffer, 4-wide push/pop).
// Define SPEC_FREE_LIST_CHECK_EN to enable the sticky overflow/bad-tag error flag.
module spec_free_list
  import spec_free_list_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  spec_free_list_if.slave fl
);

  logic [3:0] rel_valid;
  phys_tag_t  rel_tag [4];
  phys_tag_t  ctag    [4];
  logic [1:0] offset  [4];
  logic [2:0] npush;

  phys_tag_t entry_q [DEPTH];
  phys_tag_t entry_d [DEPTH];
  fl_ptr_t   head_q, head_d, tail_q, tail_d;
  fl_cnt_t   count_q, count_d;
  logic      free_valid, pop;

  assign rel_valid = {fl.releasedValid3_i, fl.releasedValid2_i,
                      fl.releasedValid1_i, fl.releasedValid0_i};
  assign rel_tag[0] = fl.releasedPhyMap0_i;
  assign rel_tag[1] = fl.releasedPhyMap1_i;
  assign rel_tag[2] = fl.releasedPhyMap2_i;
  assign rel_tag[3] = fl.releasedPhyMap3_i;

  free_list_compact u_compact (
    .valid_i  (rel_valid),
    .tag_i    (rel_tag),
    .tag_o    (ctag),
    .npush_o  (npush),
    .offset_o (offset)
  );

  assign free_valid = (count_q >= fl_cnt_t'(SLOTS));
  assign pop        = fl.reqFree_i && free_valid && !fl.recoverFlag_i;

  always_comb begin
    entry_d = entry_q;
    for (int k = 0; k < 4; k++) begin
      if (rel_valid[k]) begin
        entry_d[tail_q + fl_ptr_t'(offset[k])] = ctag[offset[k]];
      end
    end
    tail_d  = tail_q + fl_ptr_t'(npush);
    head_d  = pop ? head_q + fl_ptr_t'(SLOTS) : head_q;
    count_d = count_q + fl_cnt_t'(npush) - (pop ? fl_cnt_t'(SLOTS) : fl_cnt_t'(0));
    // Recovery keeps this cycle's releases, then declares every entry free again
    if (fl.recoverFlag_i) begin
      head_d  = tail_d;
      count_d = fl_cnt_t'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= phys_tag_t'(LOG_REGS + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= fl_cnt_t'(DEPTH);
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign fl.freeReg0_o  = entry_q[head_q];
  assign fl.freeReg1_o  = entry_q[head_q + fl_ptr_t'(1)];
  assign fl.freeReg2_o  = entry_q[head_q + fl_ptr_t'(2)];
  assign fl.freeReg3_o  = entry_q[head_q + fl_ptr_t'(3)];
  assign fl.freeValid_o = free_valid;
  assign fl.freeCount_o = count_q;

`ifdef SPEC_FREE_LIST_CHECK_EN
  typedef logic [DEPTH_LOG+1:0] fill_t;

  logic  error_q, error_d;
  logic  bad_tag;
  fill_t fill_next;

  always_comb begin
    fill_next = fill_t'(count_q) + fill_t'(npush) - (pop ? fill_t'(SLOTS) : fill_t'(0));
    bad_tag   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rel_valid[k] && (rel_tag[k] >= phys_tag_t'(PHYS_REGS))) begin
        bad_tag = 1'b1;
      end
    end
    error_d = error_q || bad_tag || (fill_next > fill_t'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign fl.error_o = error_q;
`else
  assign fl.error_o = 1'b0;
`endif

endmodule
